// File: rtl/captura_pkg.sv
// Shared types and key codes for the keypad operand capture block.
package captura_pkg;

   localparam int unsigned DIGIT_W = 4;

   typedef enum logic [1:0] {
      ENTRY_A = 2'd0,
      ENTRY_B = 2'd1,
      DONE    = 2'd2
   } state_e;

   localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hA;
   localparam logic [DIGIT_W-1:0] KEY_ENTER = 4'hB;

   // Codes 0-9 are decimal digits; everything else is a command or ignored.
   function automatic logic is_digit(input logic [DIGIT_W-1:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/captura_operandos_acumulador_digito.sv
// Digit accumulator: BCD shift register, matching binary value and digit count.
module acumulador_digito
   import captura_pkg::*;
#(
   parameter  int unsigned NUM_DIGITS = 3,
   parameter  int unsigned BIN_W      = 10,
   localparam int unsigned BCD_W      = DIGIT_W * NUM_DIGITS,
   localparam int unsigned CNT_W      = $clog2(NUM_DIGITS + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_i,
   input  logic [DIGIT_W-1:0] digit_i,
   input  logic               flush_i,
   output logic [BCD_W-1:0]   bcd_o,
   output logic [BIN_W-1:0]   bin_o,
   output logic [CNT_W-1:0]   count_o,
   output logic               full_c_o
);

   localparam int unsigned EXT_W = BIN_W + 4;

   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [EXT_W-1:0] bin_ext;

   assign bin_ext  = EXT_W'(bin_q);
   assign full_c_o = (cnt_q == CNT_W'(NUM_DIGITS));

   // Next value: flush wins over push; push shifts a digit in from the right.
   always_comb begin
      bcd_d = bcd_q;
      bin_d = bin_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         bcd_d = '0;
         bin_d = '0;
         cnt_d = '0;
      end else if (push_i && !full_c_o) begin
         bcd_d = BCD_W'({bcd_q, digit_i});
         bin_d = BIN_W'((bin_ext << 3) + (bin_ext << 1) + EXT_W'(digit_i));
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Accumulator registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_q <= '0;
         bin_q <= '0;
         cnt_q <= '0;
      end else begin
         bcd_q <= bcd_d;
         bin_q <= bin_d;
         cnt_q <= cnt_d;
      end
   end

   assign bcd_o   = bcd_q;
   assign bin_o   = bin_q;
   assign count_o = cnt_q;

endmodule

// File: rtl/captura_operandos.sv
// Keypad operand capture: assembles operands A and B and hands them downstream.
module captura_operandos
   import captura_pkg::*;
#(
   parameter  int unsigned NUM_DIGITS = 3,
   parameter  int unsigned BIN_W      = 10,
   localparam int unsigned BCD_W      = DIGIT_W * NUM_DIGITS,
   localparam int unsigned CNT_W      = $clog2(NUM_DIGITS + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_valid,
   input  logic [DIGIT_W-1:0] key_code,
   output logic [BCD_W-1:0]   entry_bcd,
   output logic [CNT_W-1:0]   entry_count,
   output logic               entry_sel,
   output logic               overflow,
   output logic [BCD_W-1:0]   op_a_bcd,
   output logic [BCD_W-1:0]   op_b_bcd,
   output logic [BIN_W-1:0]   op_a_bin,
   output logic [BIN_W-1:0]   op_b_bin,
   output logic               ops_valid,
   input  logic               ops_ready
);

   // The binary width must hold the largest NUM_DIGITS-digit decimal value.
   if ((64'd1 << BIN_W) <= (64'(10 ** NUM_DIGITS) - 64'd1)) begin : g_bin_w_chk
      $error("BIN_W too narrow for NUM_DIGITS decimal digits");
   end

   state_e            state_q, state_d;
   logic              entry_sel_q, entry_sel_d;
   logic              overflow_q, overflow_d;
   logic              ops_valid_q, ops_valid_d;
   logic [BCD_W-1:0]  op_a_bcd_q, op_a_bcd_d;
   logic [BCD_W-1:0]  op_b_bcd_q, op_b_bcd_d;
   logic [BIN_W-1:0]  op_a_bin_q, op_a_bin_d;
   logic [BIN_W-1:0]  op_b_bin_q, op_b_bin_d;

   logic              push_c, flush_c, full_c;
   logic [BCD_W-1:0]  acc_bcd;
   logic [BIN_W-1:0]  acc_bin;
   logic [CNT_W-1:0]  acc_cnt;

   logic              key_digit_c, key_clear_c, key_enter_c, xfer_c;

   assign key_digit_c = key_valid && is_digit(key_code);
   assign key_clear_c = key_valid && (key_code == KEY_CLEAR);
   assign key_enter_c = key_valid && (key_code == KEY_ENTER);
   assign xfer_c      = ops_valid_q && ops_ready;

   acumulador_digito #(
      .NUM_DIGITS (NUM_DIGITS),
      .BIN_W      (BIN_W)
   ) u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_i   (push_c),
      .digit_i  (key_code),
      .flush_i  (flush_c),
      .bcd_o    (acc_bcd),
      .bin_o    (acc_bin),
      .count_o  (acc_cnt),
      .full_c_o (full_c)
   );

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ENTRY_A;
         entry_sel_q <= 1'b0;
         overflow_q  <= 1'b0;
         ops_valid_q <= 1'b0;
         op_a_bcd_q  <= '0;
         op_b_bcd_q  <= '0;
         op_a_bin_q  <= '0;
         op_b_bin_q  <= '0;
      end else begin
         state_q     <= state_d;
         entry_sel_q <= entry_sel_d;
         overflow_q  <= overflow_d;
         ops_valid_q <= ops_valid_d;
         op_a_bcd_q  <= op_a_bcd_d;
         op_b_bcd_q  <= op_b_bcd_d;
         op_a_bin_q  <= op_a_bin_d;
         op_b_bin_q  <= op_b_bin_d;
      end
   end

   // Next-state, accumulator control and commit muxing; clear overrides everything.
   always_comb begin
      state_d     = state_q;
      entry_sel_d = entry_sel_q;
      overflow_d  = 1'b0;
      ops_valid_d = ops_valid_q;
      op_a_bcd_d  = op_a_bcd_q;
      op_b_bcd_d  = op_b_bcd_q;
      op_a_bin_d  = op_a_bin_q;
      op_b_bin_d  = op_b_bin_q;
      push_c      = 1'b0;
      flush_c     = 1'b0;

      if (key_clear_c) begin
         state_d     = ENTRY_A;
         entry_sel_d = 1'b0;
         ops_valid_d = 1'b0;
         op_a_bcd_d  = '0;
         op_b_bcd_d  = '0;
         op_a_bin_d  = '0;
         op_b_bin_d  = '0;
         flush_c     = 1'b1;
      end else begin
         unique case (state_q)
            ENTRY_A, ENTRY_B: begin
               if (key_digit_c) begin
                  if (full_c) begin
                     overflow_d = 1'b1;
                  end else begin
                     push_c = 1'b1;
                  end
               end else if (key_enter_c && (acc_cnt != '0)) begin
                  flush_c = 1'b1;
                  if (state_q == ENTRY_A) begin
                     op_a_bcd_d  = acc_bcd;
                     op_a_bin_d  = acc_bin;
                     entry_sel_d = 1'b1;
                     state_d     = ENTRY_B;
                  end else begin
                     op_b_bcd_d  = acc_bcd;
                     op_b_bin_d  = acc_bin;
                     ops_valid_d = 1'b1;
                     state_d     = DONE;
                  end
               end
            end
            DONE: begin
               if (xfer_c) begin
                  ops_valid_d = 1'b0;
                  entry_sel_d = 1'b0;
                  state_d     = ENTRY_A;
               end
            end
            default: begin
               state_d = ENTRY_A;
            end
         endcase
      end
   end

   assign entry_bcd   = acc_bcd;
   assign entry_count = acc_cnt;
   assign entry_sel   = entry_sel_q;
   assign overflow    = overflow_q;
   assign op_a_bcd    = op_a_bcd_q;
   assign op_b_bcd    = op_b_bcd_q;
   assign op_a_bin    = op_a_bin_q;
   assign op_b_bin    = op_b_bin_q;
   assign ops_valid   = ops_valid_q;

endmodule

// File: tb/tb_captura_operandos.sv
// Bench for captura_operandos: directed plan steps plus random keys vs. an integer model.
module tb_captura_operandos;

   localparam int unsigned ND    = 3;
   localparam int unsigned BW    = 10;
   localparam int unsigned BCD_W = 4 * ND;
   localparam int unsigned CNT_W = $clog2(ND + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             key_valid;
   logic [3:0]       key_code;
   logic [BCD_W-1:0] entry_bcd;
   logic [CNT_W-1:0] entry_count;
   logic             entry_sel;
   logic             overflow;
   logic [BCD_W-1:0] op_a_bcd, op_b_bcd;
   logic [BW-1:0]    op_a_bin, op_b_bin;
   logic             ops_valid;
   logic             ops_ready;

   captura_operandos #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .entry_bcd   (entry_bcd),
      .entry_count (entry_count),
      .entry_sel   (entry_sel),
      .overflow    (overflow),
      .op_a_bcd    (op_a_bcd),
      .op_b_bcd    (op_b_bcd),
      .op_a_bin    (op_a_bin),
      .op_b_bin    (op_b_bin),
      .ops_valid   (ops_valid),
      .ops_ready   (ops_ready)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: plain integers for the operand being typed and the committed ones.
   int m_phase;   // 0 typing A, 1 typing B, 2 both committed
   int m_val;
   int m_n;
   int m_a;
   int m_b;
   int m_valid;
   int m_ovf;

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r = '0;
      int x = v;
      for (int i = 0; i < int'(ND); i++) begin
         r = r | (32'(x % 10) << (4 * i));
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_val = 0; m_n = 0; m_a = 0; m_b = 0; m_valid = 0; m_ovf = 0;
   endtask

   task automatic model_edge(input logic v, input logic [3:0] c, input logic r);
      m_ovf = 0;
      if (v && c == 4'hA) begin
         model_reset();
      end else if (m_phase == 2) begin
         if (m_valid != 0 && r) begin
            m_valid = 0;
            m_phase = 0;
         end
      end else if (v && c <= 4'd9) begin
         if (m_n == int'(ND)) m_ovf = 1;
         else begin
            m_val = m_val * 10 + int'(c);
            m_n++;
         end
      end else if (v && c == 4'hB && m_n > 0) begin
         if (m_phase == 0) begin
            m_a = m_val;
            m_phase = 1;
         end else begin
            m_b = m_val;
            m_phase = 2;
            m_valid = 1;
         end
         m_val = 0;
         m_n = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("entry_bcd",   32'(entry_bcd),   to_bcd(m_val));
      chk("entry_count", 32'(entry_count), 32'(m_n));
      chk("entry_sel",   32'(entry_sel),   32'(m_phase != 0));
      chk("overflow",    32'(overflow),    32'(m_ovf));
      chk("op_a_bcd",    32'(op_a_bcd),    to_bcd(m_a));
      chk("op_b_bcd",    32'(op_b_bcd),    to_bcd(m_b));
      chk("op_a_bin",    32'(op_a_bin),    32'(m_a));
      chk("op_b_bin",    32'(op_b_bin),    32'(m_b));
      chk("ops_valid",   32'(ops_valid),   32'(m_valid));
   endtask

   // One clock: drive at negedge, model the edge, sample 1 time unit after it.
   task automatic step(input logic v, input logic [3:0] c, input logic r);
      @(negedge clk);
      key_valid = v;
      key_code  = c;
      ops_ready = r;
      @(posedge clk);
      model_edge(v, c, r);
      #1;
      check_all();
      key_valid = 1'b0;
      ops_ready = 1'b0;
   endtask

   task automatic key(input logic [3:0] c);
      step(1'b1, c, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_code  = 4'h0;
      ops_ready = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // 123 # 45 # with no ready: both committed and held.
      key(4'd1); key(4'd2); key(4'd3); key(4'hB);
      key(4'd4); key(4'd5); key(4'hB);
      chk("plan1_a_bcd", 32'(op_a_bcd), 32'h123);
      chk("plan1_a_bin", 32'(op_a_bin), 32'd123);
      chk("plan1_b_bcd", 32'(op_b_bcd), 32'h045);
      chk("plan1_b_bin", 32'(op_b_bin), 32'd45);
      chk("plan1_valid", 32'(ops_valid), 32'd1);
      repeat (20) step(1'b0, 4'h0, 1'b0);

      // One-cycle ready pulse completes the transfer.
      step(1'b0, 4'h0, 1'b1);
      chk("xfer_valid", 32'(ops_valid), 32'd0);
      chk("xfer_sel",   32'(entry_sel), 32'd0);
      chk("xfer_count", 32'(entry_count), 32'd0);
      key(4'd7);
      chk("xfer_entry7", 32'(entry_bcd), 32'h007);
      key(4'hA);

      // Overflow on the fourth digit only.
      key(4'd9); key(4'd9); key(4'd9);
      chk("ovf_before", 32'(overflow), 32'd0);
      key(4'd9);
      chk("ovf_pulse", 32'(overflow), 32'd1);
      chk("ovf_bcd",   32'(entry_bcd), 32'h999);
      chk("ovf_count", 32'(entry_count), 32'd3);
      step(1'b0, 4'h0, 1'b0);
      chk("ovf_drop", 32'(overflow), 32'd0);
      key(4'hA);

      // Enter with an empty entry is ignored in both entry states.
      key(4'hB);
      chk("empty_enter_a", 32'(entry_sel), 32'd0);
      key(4'd1); key(4'hB); key(4'hB);
      chk("empty_enter_b", 32'(entry_sel), 32'd1);
      chk("empty_enter_valid", 32'(ops_valid), 32'd0);
      key(4'hA);

      // Clear mid-entry of B, then clear together with ready in DONE.
      key(4'd5); key(4'hB); key(4'd6); key(4'hA);
      chk("clr_sel",  32'(entry_sel), 32'd0);
      chk("clr_bcd",  32'(entry_bcd), 32'd0);
      chk("clr_opa",  32'(op_a_bcd), 32'd0);
      key(4'd5); key(4'hB); key(4'd6); key(4'hB);
      step(1'b1, 4'hA, 1'b1);
      chk("clr_xfer_valid", 32'(ops_valid), 32'd0);
      chk("clr_xfer_sel",   32'(entry_sel), 32'd0);

      // Asynchronous reset between edges after 3 #.
      key(4'd3); key(4'hB);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      key(4'd8); key(4'hB); key(4'd2); key(4'hB);
      chk("rst_a_bin", 32'(op_a_bin), 32'd8);
      chk("rst_b_bin", 32'(op_b_bin), 32'd2);
      step(1'b0, 4'h0, 1'b1);

      // Random key stream against the model.
      for (int i = 0; i < 600; i++) begin
         int unsigned sel;
         logic        v;
         logic [3:0]  c;
         logic        r;
         sel = $urandom_range(0, 99);
         v   = 1'b1;
         if (sel < 55)      c = 4'($urandom_range(0, 9));
         else if (sel < 70) c = 4'hB;
         else if (sel < 73) c = 4'hA;
         else if (sel < 80) c = 4'($urandom_range(12, 15));
         else begin
            v = 1'b0;
            c = 4'($urandom_range(0, 15));
         end
         r = ($urandom_range(0, 3) == 0);
         step(v, c, r);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
